// File: rtl/uart_rx_word_pkg.sv
// Shared types and constants for the UART word receiver.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_rx_word_pkg;

  localparam int unsigned DEF_CLK_PER_BIT = 868;
  localparam int unsigned BYTES_PER_WORD  = 4;
  localparam int unsigned WORD_W          = 8 * BYTES_PER_WORD;
  localparam int unsigned IDX_W           = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_word_if.sv
// Serial input, alignment control and byte/word outputs of the receiver.
interface uart_rx_word_if;
  import uart_rx_word_pkg::*;

  logic              rxd;
  logic              align_clr;
  logic [7:0]        rbyte;
  logic              rbyte_valid;
  logic [WORD_W-1:0] rdata_buf;
  logic              rdata_buf_ready;
  logic              frame_err;
  logic [IDX_W-1:0]  byte_idx;

  modport master (
    input  rxd, align_clr,
    output rbyte, rbyte_valid, rdata_buf, rdata_buf_ready, frame_err, byte_idx
  );

  modport slave (
    output rxd, align_clr,
    input  rbyte, rbyte_valid, rdata_buf, rdata_buf_ready, frame_err, byte_idx
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw serial line plus a falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic rxd,
  output logic rx_s,
  output logic rx_fall
);

  // [1:0] is the synchroniser, [2] is one cycle of history for the edge
  logic [2:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[1:0], rxd};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '1;
    else       sync_q <= sync_d;
  end

  assign rx_s    = sync_q[1];
  assign rx_fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart_rx_word.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) that packs good bytes
// little-endian into a 32-bit word and flags framing/parity errors.
module uart_rx_word
  import uart_rx_word_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = DEF_CLK_PER_BIT
) (
  input  logic           clk,
  input  logic           rstn,
  uart_rx_word_if.master bus
);

  localparam logic [15:0] FULL_M1 = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] HALF_M1 = 16'(CLK_PER_BIT / 2 - 1);

  logic rx_s, rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .rxd     (bus.rxd),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  rx_state_e         state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic [7:0]        rbyte_q, rbyte_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d, idx_eff;
  logic              vld_q, vld_d;
  logic              rdy_q, rdy_d;
  logic              ferr_q, ferr_d;
  logic              tick, stop_done, stop_ok;
`ifdef UART_RX_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  assign tick = (cnt_q == FULL_M1);

  // Bit-level framing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_d     = bit_q;
    sh_d      = sh_q;
    stop_done = 1'b0;
    stop_ok   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_fall) begin
          state_d = ST_START;
          bit_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          cnt_d     = '0;
          par_err_d = rx_s ^ (^sh_q);
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          cnt_d     = '0;
          state_d   = ST_IDLE;
          stop_done = 1'b1;
`ifdef UART_RX_PARITY_EN
          stop_ok   = rx_s & ~par_err_q;
`else
          stop_ok   = rx_s;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Word assembly; align_clr in the completion cycle redirects the byte to lane 0
  always_comb begin
    idx_eff = bus.align_clr ? '0 : idx_q;
    rbyte_d = rbyte_q;
    word_d  = word_q;
    idx_d   = idx_eff;
    vld_d   = 1'b0;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;
    if (stop_done && stop_ok) begin
      rbyte_d                         = sh_q;
      word_d[{idx_eff, 3'b000} +: 8]  = sh_q;
      vld_d                           = 1'b1;
      rdy_d                           = (idx_eff == IDX_W'(BYTES_PER_WORD - 1));
      idx_d                           = idx_eff + IDX_W'(1);
    end else if (stop_done) begin
      ferr_d = 1'b1;
      idx_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rbyte_q <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rbyte_q <= rbyte_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      rdy_q   <= rdy_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) par_err_q <= 1'b0;
    else       par_err_q <= par_err_d;
  end
`endif

  assign bus.rbyte           = rbyte_q;
  assign bus.rbyte_valid     = vld_q;
  assign bus.rdata_buf       = word_q;
  assign bus.rdata_buf_ready = rdy_q;
  assign bus.frame_err       = ferr_q;
  assign bus.byte_idx        = idx_q;

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: directed scenarios plus random frames, all scored
// against an event-queue model of bytes, words and frame errors.
module tb_uart_rx_word;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_rx_word_if bus();

  uart_rx_word #(.CLK_PER_BIT(CPB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic        bad;
    logic [7:0]  b;
    logic        rdy;
    logic [31:0] word;
    logic [1:0]  idx;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] m_word;
  logic [1:0]  m_idx;
  int          tests = 0;
  int          fails = 0;
  int          n_vld = 0, n_rdy = 0, n_ferr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: what the receiver must report for one complete frame
  function automatic void model_frame(input logic [7:0] d, input logic good);
    ev_t e;
    e.bad = !good;
    e.b   = d;
    e.rdy = 1'b0;
    if (good) begin
      m_word[8*m_idx +: 8] = d;
      e.rdy = (m_idx == 2'd3);
      m_idx = m_idx + 2'd1;
    end else begin
      m_idx = 2'd0;
    end
    e.word = m_word;
    e.idx  = m_idx;
    exp_q.push_back(e);
  endfunction

  // Compare process: every pulse must match the next model event
  always @(negedge clk) begin : cmp
    ev_t e;
    if (rstn && (bus.rbyte_valid || bus.frame_err || bus.rdata_buf_ready)) begin
      n_vld  += int'(bus.rbyte_valid);
      n_rdy  += int'(bus.rdata_buf_ready);
      n_ferr += int'(bus.frame_err);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse",
              {29'd0, bus.rbyte_valid, bus.rdata_buf_ready, bus.frame_err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, bus.rbyte_valid, bus.frame_err},
              e.bad ? 32'd1 : 32'd2);
        check("word_ready", {31'd0, bus.rdata_buf_ready}, {31'd0, e.rdy});
        check("byte_idx", 32'(bus.byte_idx), 32'(e.idx));
        check("rdata_buf", bus.rdata_buf, e.word);
        if (!e.bad) check("rbyte", 32'(bus.rbyte), 32'(e.b));
      end
    end
  end

  task automatic bit_time();
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
`ifdef UART_RX_PARITY_EN
    model_frame(d, stop_b && !par_flip);
`else
    model_frame(d, stop_b);
`endif
    bus.rxd = 1'b0;
    bit_time();
    for (int i = 0; i < 8; i++) begin
      bus.rxd = d[i];
      bit_time();
    end
`ifdef UART_RX_PARITY_EN
    bus.rxd = (^d) ^ par_flip;
    bit_time();
`endif
    bus.rxd = stop_b;
    bit_time();
    bus.rxd = 1'b1;
    bit_time();
    bit_time();
  endtask

  task automatic good(input logic [7:0] d);
    send_frame(d, 1'b1, 1'b0);
  endtask

  task automatic do_align();
    bus.align_clr = 1'b1;
    @(negedge clk);
    bus.align_clr = 1'b0;
    m_idx = 2'd0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rbyte"},     32'(bus.rbyte), 32'd0);
    check({tag, "_vld"},       32'(bus.rbyte_valid), 32'd0);
    check({tag, "_rdata_buf"}, bus.rdata_buf, 32'd0);
    check({tag, "_rdy"},       32'(bus.rdata_buf_ready), 32'd0);
    check({tag, "_ferr"},      32'(bus.frame_err), 32'd0);
    check({tag, "_idx"},       32'(bus.byte_idx), 32'd0);
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int s_vld, s_ferr;
    logic [7:0] d;
    bus.rxd       = 1'b1;
    bus.align_clr = 1'b0;
    m_word        = '0;
    m_idx         = '0;
    rstn          = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Test 1: basic word
    good(8'h78); good(8'h56); good(8'h34); good(8'h12);
    check("t1_word", bus.rdata_buf, 32'h12345678);
    check("t1_nvld", n_vld, 32'd4);
    check("t1_nrdy", n_rdy, 32'd1);

    // Test 2: short low glitch is rejected
    s_vld = n_vld; s_ferr = n_ferr;
    bus.rxd = 1'b0;
    repeat (4) @(negedge clk);
    bus.rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("t2_no_vld", n_vld, s_vld);
    check("t2_no_ferr", n_ferr, s_ferr);

    // Test 3: bad stop drops partial word
    good(8'h11); good(8'h22);
    send_frame(8'hA5, 1'b0, 1'b0);
    check("t3_ferr_cnt", n_ferr, 32'(s_ferr + 1));
    check("t3_idx", 32'(bus.byte_idx), 32'd0);
    good(8'h01); good(8'h02); good(8'h03); good(8'h04);
    check("t3_word", bus.rdata_buf, 32'h04030201);

    // Test 4: realign after 3 bytes
    good(8'h99); good(8'h88); good(8'h77);
    do_align();
    check("t4_idx_cleared", 32'(bus.byte_idx), 32'd0);
    good(8'hEF); good(8'hBE); good(8'hAD); good(8'hDE);
    check("t4_word", bus.rdata_buf, 32'hDEADBEEF);

    // Test 5: reset at data bit 4
    s_vld = n_vld;
    bus.rxd = 1'b0;
    bit_time();
    for (int i = 0; i < 4; i++) begin
      bus.rxd = i[0];
      bit_time();
    end
    rstn    = 1'b0;
    bus.rxd = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("t5_rst");
    rstn   = 1'b1;
    m_word = '0;
    m_idx  = '0;
    repeat (3 * CPB) @(negedge clk);
    check("t5_no_vld", n_vld, s_vld);
    good(8'h3C);
    check("t5_rbyte", 32'(bus.rbyte), 32'h3C);
    check("t5_word", bus.rdata_buf, 32'h0000003C);

    // Line held low much longer than a frame: exactly one error
    s_ferr = n_ferr;
    model_frame(8'h00, 1'b0);
    bus.rxd = 1'b0;
    repeat (25) bit_time();
    bus.rxd = 1'b1;
    repeat (3) bit_time();
    check("long_low_ferr", n_ferr, 32'(s_ferr + 1));

`ifdef UART_RX_PARITY_EN
    // Test 6: even parity
    s_ferr = n_ferr;
    send_frame(8'h03, 1'b1, 1'b1);
    check("t6_par_ferr", n_ferr, 32'(s_ferr + 1));
    good(8'h03);
    check("t6_rbyte", 32'(bus.rbyte), 32'h03);
`endif

    // Random frames with occasional bad stops, parity flips and realigns
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) do_align();
      send_frame(d, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, CPB)) @(negedge clk);
    end

    for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_word.md
UART_RX_WORD -- requirements
Module: uart_rx_word

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 16..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port rxd  input  1  raw UART serial line; asynchronous, idle high.
REQ-005 SHALL have port align_clr  input  1  synchronous; discards any partial word and restarts at byte 0.
REQ-006 SHALL have port rbyte  output  8  last received byte.
REQ-007 SHALL have port rbyte_valid  output  1  one-cycle pulse per good byte.
REQ-008 SHALL have port rdata_buf  output  32  assembled little-endian word.
REQ-009 SHALL have port rdata_buf_ready  output  1  one-cycle pulse per completed word.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on bad stop or parity bit.
REQ-011 SHALL have port byte_idx  output  2  number of bytes held in the partial word.

Function
REQ-012 SHALL pass rxd through a two-flop synchroniser; all decisions use the synchronised value only.
REQ-013 SHALL implement FSM IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
REQ-014 IDLE: synchronised 1->0 edge enters START with bit counter cleared.
REQ-015 START: at CLK_PER_BIT/2 cycles, line 0 -> DATA; line 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: sample every CLK_PER_BIT cycles, 8 bits, LSB first, shifted into a byte register.
REQ-017 STOP: sample once CLK_PER_BIT after the last data/parity sample; sample 1 = good byte, sample 0 = frame error; return to IDLE the next cycle in both cases.
REQ-018 A good byte SHALL assert rbyte_valid for exactly one cycle, in the cycle after the stop sample, with rbyte stable from that cycle until the next good byte.
REQ-019 A good byte SHALL be written to rdata_buf lane byte_idx ([8*i+7:8*i]), then byte_idx increments modulo 4.
REQ-020 On the 4th good byte (byte_idx 3), rdata_buf_ready SHALL pulse in the same cycle as rbyte_valid, rdata_buf SHALL show the full word, and byte_idx SHALL wrap to 0.
REQ-021 rdata_buf SHALL hold its value between pulses; the consumer samples on the pulse only (no backpressure, no overrun detection).
REQ-022 A frame error SHALL pulse frame_err for one cycle, suppress rbyte_valid, and clear byte_idx to 0 (partial word dropped).
REQ-023 align_clr SHALL clear byte_idx to 0 without disturbing the bit-level FSM; if asserted in the same cycle as a good-byte completion, the byte SHALL be stored in lane 0, byte_idx SHALL become 1, and rdata_buf_ready SHALL NOT pulse.
REQ-024 Line held low for longer than a full frame SHALL raise exactly one frame_err, then wait in IDLE for a new 1->0 edge.

Reset
REQ-025 While rstn = 0: FSM in IDLE, synchroniser flops = 1, counters = 0, rbyte = 0, rdata_buf = 0, byte_idx = 0, all pulses = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no pulse; reception resumes on the first 1->0 edge after release.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: a PARITY state samples one even-parity bit after bit 7; a mismatch is treated as a frame error per REQ-022.
REQ-028 Macro undefined: no PARITY state and no parity logic; frame is 8N1.

Structure
REQ-029 Shared package SHALL hold the FSM state enum, default CLK_PER_BIT, and the word-lane constant (4 bytes/word).
REQ-030 Synchroniser plus edge detect SHALL be a sub-module named uart_rx_sync.

Verification
REQ-031 Test 1: CLK_PER_BIT=16, bytes 0x78,0x56,0x34,0x12 in 8N1 -> four rbyte_valid pulses; one rdata_buf_ready with rdata_buf=0x12345678 on the 4th.
REQ-032 Test 2: 4-cycle low glitch on rxd -> no rbyte_valid, no frame_err, FSM back in IDLE.
REQ-033 Test 3: byte 0xA5 with stop bit 0 after 2 good bytes -> frame_err pulse, byte_idx=0; next 4 good bytes form a fresh word.
REQ-034 Test 4: align_clr after 3 bytes, then 0xEF,0xBE,0xAD,0xDE -> rdata_buf=0xDEADBEEF.
REQ-035 Test 5: rstn pulled low at bit 4 of a byte -> all outputs 0, no pulses; next clean byte received correctly.
REQ-036 Test 6 (UART_RX_PARITY_EN): 0x03 with parity 1 -> frame_err; with parity 0 -> rbyte=0x03.
